// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: states, opcodes,
// ALU/immediate codes, mux selects and the per-state control bundle.
package mc_ctrl_pkg;

    localparam int unsigned STATE_BITS = 4;

    typedef enum logic [STATE_BITS-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        alu_op_e    alu_op;
    } ctrl_t;

    // Moore output table; unused encodings drive everything inactive.
    function automatic ctrl_t state_ctrl(input state_e s);
        ctrl_t c;
        c            = '0;
        c.alu_op     = ALUOP_ADD;
        case (s)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.pc_update  = 1'b1;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: c.reg_write = 1'b1;
            S_BEQ: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_op    = ALUOP_SUB;
                c.branch    = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_FOUR;
                c.pc_update = 1'b1;
            end
            default: c = c;
        endcase
        return c;
    endfunction

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] imm;
        case (op)
            OP_SW:   imm = IMM_S;
            OP_BEQ:  imm = IMM_B;
            OP_JAL:  imm = IMM_J;
            default: imm = IMM_I;
        endcase
        return imm;
    endfunction

    function automatic logic op_supported(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps alu_op plus instruction fields to the
// 3-bit ALU operation select.
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  alu_op_e    alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       op5_i,
    input  logic       funct7b5_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I main control FSM with ALU and immediate decode.
// Define MC_CTRL_PERF_EN to add the 32-bit retired-instruction counter.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned          STATE_W     = 4,
    parameter logic [STATE_W-1:0]   RESET_STATE = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        zero,
    output logic        pc_write,
    output logic        adr_src,
    output logic        mem_write,
    output logic        ir_write,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_control,
    output logic [1:0]  imm_src,
    output logic        reg_write,
    output logic        illegal
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] instret
`endif
);

    localparam state_e RST_STATE = state_e'(RESET_STATE);

    state_e state_q, state_d;
    ctrl_t  ctrl_q;
    ctrl_t  ctrl_c;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: state_d = S_MEMWB;
            S_EXECR:   state_d = S_ALUWB;
            S_EXECI:   state_d = S_ALUWB;
            S_JAL:     state_d = S_ALUWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // Control outputs are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RST_STATE;
            ctrl_q  <= state_ctrl(RST_STATE);
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_ctrl(state_d);
        end
    end

    // During reset show the reset-state values with every strobe held low.
    always_comb begin
        ctrl_c = ctrl_q;
        if (rst) begin
            ctrl_c           = state_ctrl(RST_STATE);
            ctrl_c.pc_update = 1'b0;
            ctrl_c.branch    = 1'b0;
            ctrl_c.mem_write = 1'b0;
            ctrl_c.ir_write  = 1'b0;
            ctrl_c.reg_write = 1'b0;
        end
    end

    assign pc_write   = ctrl_c.pc_update | (ctrl_c.branch & zero);
    assign adr_src    = ctrl_c.adr_src;
    assign mem_write  = ctrl_c.mem_write;
    assign ir_write   = ctrl_c.ir_write;
    assign reg_write  = ctrl_c.reg_write;
    assign result_src = ctrl_c.result_src;
    assign alu_src_a  = ctrl_c.alu_src_a;
    assign alu_src_b  = ctrl_c.alu_src_b;
    assign imm_src    = imm_src_of(op);
    assign illegal    = (state_q == S_DECODE) & ~op_supported(op) & ~rst;

    alu_decoder u_alu_decoder (
        .alu_op_i      (ctrl_c.alu_op),
        .funct3_i      (funct3),
        .op5_i         (op[5]),
        .funct7b5_i    (funct7b5),
        .alu_control_o (alu_control)
    );

`ifdef MC_CTRL_PERF_EN
    logic [31:0] instret_q;
    logic        retire;

    // An instruction retires on the edge that leaves its final state.
    assign retire = (state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                    (state_q == S_ALUWB) || (state_q == S_BEQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instruction sequences
// followed by random instructions against a cycle-table reference model.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;

    int checks = 0;
    int errors = 0;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5, K_ILL = 6;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control), .imm_src(imm_src),
        .reg_write(reg_write), .illegal(illegal)
    );

    function automatic int latency(input int k);
        case (k)
            K_LW:    return 5;
            K_BEQ:   return 3;
            K_ILL:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [6:0] op_of(input int k);
        case (k)
            K_LW:    return 7'b0000011;
            K_SW:    return 7'b0100011;
            K_R:     return 7'b0110011;
            K_I:     return 7'b0010011;
            K_BEQ:   return 7'b1100011;
            K_JAL:   return 7'b1101111;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [1:0] ref_imm(input logic [6:0] o);
        if (o == 7'b0100011) return 2'd1;
        if (o == 7'b1100011) return 2'd2;
        if (o == 7'b1101111) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [2:0] ref_funct_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0:    return (o[5] && f7) ? 3'b001 : 3'b000;
            3'd2:    return 3'b101;
            3'd6:    return 3'b011;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Expected {pc_write,adr_src,mem_write,ir_write,result_src,alu_src_a,
    //           alu_src_b,alu_control,imm_src,reg_write,illegal}
    function automatic logic [16:0] ref_out(input int k, input int cyc, input logic [6:0] o,
                                            input logic [2:0] f3, input logic f7,
                                            input logic z, input logic r);
        logic pcw, adr, mw, irw, rw, ill;
        logic [1:0] res, sa, sb;
        logic [2:0] alu;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
        res = 0; sa = 0; sb = 0; alu = 3'b000;
        if (r || cyc == 0) begin
            sb = 2'd2; res = 2'd2;
            if (!r) begin irw = 1; pcw = 1; end
        end else if (cyc == 1) begin
            sa = 2'd1; sb = 2'd1; ill = (k == K_ILL);
        end else begin
            case (k)
                K_LW: begin
                    if (cyc == 2) begin sa = 2'd2; sb = 2'd1; end
                    if (cyc == 3) adr = 1;
                    if (cyc == 4) begin res = 2'd1; rw = 1; end
                end
                K_SW: begin
                    if (cyc == 2) begin sa = 2'd2; sb = 2'd1; end
                    if (cyc == 3) begin adr = 1; mw = 1; end
                end
                K_R: begin
                    if (cyc == 2) begin sa = 2'd2; alu = ref_funct_alu(o, f3, f7); end
                    if (cyc == 3) rw = 1;
                end
                K_I: begin
                    if (cyc == 2) begin sa = 2'd2; sb = 2'd1; alu = ref_funct_alu(o, f3, f7); end
                    if (cyc == 3) rw = 1;
                end
                K_BEQ: begin
                    sa = 2'd2; alu = 3'b001; pcw = z;
                end
                K_JAL: begin
                    if (cyc == 2) begin sa = 2'd1; sb = 2'd2; pcw = 1; end
                    if (cyc == 3) rw = 1;
                end
                default: ;
            endcase
        end
        return {pcw, adr, mw, irw, res, sa, sb, alu, ref_imm(o), rw, ill};
    endfunction

    task automatic check(input string tag, input logic [16:0] exp);
        logic [16:0] obs;
        obs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
               alu_src_b, alu_control, imm_src, reg_write, illegal};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Caller is 1 time unit after the edge that entered FETCH.
    // zmode: 0/1 force zero, 2 random. rst_cyc < 0 means no reset.
    task automatic run_instr(input string tag, input int k, input logic [6:0] o,
                             input logic [2:0] f3, input logic f7,
                             input int zmode, input int rst_cyc);
        bit aborted;
        aborted = 0;
        op = o; funct3 = f3; funct7b5 = f7;
        for (int cyc = 0; cyc < latency(k) && !aborted; cyc++) begin
            zero = (zmode == 2) ? 1'($urandom_range(1)) : 1'(zmode);
            rst  = (cyc == rst_cyc);
            @(negedge clk);
            check($sformatf("%s_c%0d", tag, cyc), ref_out(k, cyc, o, f3, f7, zero, rst));
            @(posedge clk);
            #1;
            if (rst) begin
                rst = 0;
                aborted = 1;
            end
        end
    endtask

    initial begin
        int k, rc;
        logic [6:0] rop;
        rst = 1; op = 7'b0000011; funct3 = 0; funct7b5 = 0; zero = 0;
        repeat (2) begin
            @(negedge clk);
            check("reset_hold", ref_out(K_LW, 0, op, funct3, funct7b5, zero, 1'b1));
        end
        @(posedge clk);
        #1;
        rst = 0;

        run_instr("lw",     K_LW,  op_of(K_LW),  3'd2, 1'b0, 2, -1);
        run_instr("sw",     K_SW,  op_of(K_SW),  3'd2, 1'b0, 2, -1);
        run_instr("beq_z1", K_BEQ, op_of(K_BEQ), 3'd0, 1'b0, 1, -1);
        run_instr("beq_z0", K_BEQ, op_of(K_BEQ), 3'd0, 1'b0, 0, -1);
        run_instr("r_sub",  K_R,   op_of(K_R),   3'd0, 1'b1, 2, -1);
        run_instr("r_or",   K_R,   op_of(K_R),   3'd6, 1'b0, 2, -1);
        run_instr("i_add",  K_I,   op_of(K_I),   3'd0, 1'b1, 2, -1);
        run_instr("i_and",  K_I,   op_of(K_I),   3'd7, 1'b0, 2, -1);
        run_instr("jal",    K_JAL, op_of(K_JAL), 3'd0, 1'b0, 2, -1);
        run_instr("illegal",K_ILL, 7'b1111111,   3'd0, 1'b0, 2, -1);
        run_instr("lw_rst", K_LW,  op_of(K_LW),  3'd2, 1'b0, 2, 3);
        run_instr("after_rst", K_SW, op_of(K_SW), 3'd2, 1'b0, 2, -1);

        for (int n = 0; n < 300; n++) begin
            k = int'($urandom_range(6));
            rop = op_of(k);
            if (k == K_ILL) begin
                do rop = 7'($urandom);
                while (rop == 7'b0000011 || rop == 7'b0100011 || rop == 7'b0110011 ||
                       rop == 7'b0010011 || rop == 7'b1100011 || rop == 7'b1101111);
            end
            rc = ($urandom_range(9) == 0) ? int'($urandom_range(latency(k) - 1)) : -1;
            run_instr("rand", k, rop, 3'($urandom), 1'($urandom), 2, rc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control unit for the multi-cycle RV32I core variant. It is a Moore FSM plus a combinational ALU decoder and immediate-format decoder. It sequences the shared ALU, memory port, instruction register and register file across cycles, and drives imm_src to the immediate extension unit. Supported instructions: lw, sw, R-type, I-type ALU, beq, jal.

Parameters:
- STATE_W, 4, width of the state register.
- RESET_STATE, 4'd0, state entered on reset (FETCH).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  7  instr[6:0].
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- zero  in  1  ALU zero flag from the current cycle.
- pc_write  out  1  PC register enable.
- adr_src  out  1  memory address mux: 0 = PC, 1 = ALUOut.
- mem_write  out  1  data memory write strobe.
- ir_write  out  1  instruction register / OldPC enable.
- result_src  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- alu_src_a  out  2  ALU A mux: 00 = PC, 01 = OldPC, 10 = RD1.
- alu_src_b  out  2  ALU B mux: 00 = RD2, 01 = ImmExt, 10 = constant 4.
- alu_control  out  3  000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- imm_src  out  2  00 = I, 01 = S, 10 = B, 11 = J.
- reg_write  out  1  register file write enable.
- illegal  out  1  one-cycle pulse when DECODE sees an unsupported opcode.

Behaviour:
- One clock, clk. Reset is synchronous and active-high: rst sampled high at a rising edge loads state = FETCH. While rst is high, pc_write, ir_write, mem_write, reg_write and illegal are forced to 0. All other outputs show their FETCH values.
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BEQ 9, JAL 10. Encodings 11–15 go to FETCH on the next edge.
- Transitions:
  - FETCH -> DECODE.
  - DECODE -> MEMADR for lw (0000011) and sw (0100011).
  - DECODE -> EXECR for 0110011.
  - DECODE -> EXECI for 0010011.
  - DECODE -> BEQ for 1100011.
  - DECODE -> JAL for 1101111.
  - DECODE -> FETCH for any other opcode, with illegal = 1 that cycle.
  - MEMADR -> MEMREAD if op[5] = 0, else MEMWRITE.
  - MEMREAD -> MEMWB.
  - EXECR and EXECI -> ALUWB.
  - JAL -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BEQ -> FETCH.
- Per-state outputs. Any output not listed is 0 (alu_op 00).
  - FETCH: ir_write = 1, pc_update = 1, alu_src_b = 10, result_src = 10.
  - DECODE: alu_src_a = 01, alu_src_b = 01 (branch target).
  - MEMADR: alu_src_a = 10, alu_src_b = 01.
  - MEMREAD: adr_src = 1.
  - MEMWB: result_src = 01, reg_write = 1.
  - MEMWRITE: adr_src = 1, mem_write = 1.
  - EXECR: alu_src_a = 10, alu_op = 10.
  - EXECI: alu_src_a = 10, alu_src_b = 01, alu_op = 10.
  - ALUWB: reg_write = 1.
  - BEQ: alu_src_a = 10, alu_op = 01, branch = 1.
  - JAL: alu_src_a = 01, alu_src_b = 10, pc_update = 1.
- pc_write = pc_update | (branch & zero). This term is combinational on zero in the same cycle.
- ALU decoder:
  - alu_op 00 -> add; alu_op 01 -> sub.
  - alu_op 10, funct3 000 -> sub if (op[5] & funct7b5), else add.
  - alu_op 10, funct3 010 -> slt; 110 -> or; 111 -> and.
  - alu_op 10, any other funct3 -> add.
- imm_src is combinational from op in every state:
  - lw and I-type -> 00; sw -> 01; beq -> 10; jal -> 11; other opcodes -> 00.
- Latency in cycles, FETCH inclusive: lw 5, sw 4, R 4, I 4, beq 3, jal 4, illegal 2.
- rst asserted mid-instruction: the next edge returns to FETCH. Any write strobe is suppressed from the cycle rst is high.

Optional Feature:
- Macro: MC_CTRL_PERF_EN.
- Defined: adds output instret (32 bits). It is cleared by rst and increments by 1 on each edge where the state leaves MEMWB, MEMWRITE, ALUWB or BEQ. It wraps at 2^32−1 to 0 and does not count illegal opcodes.
- Undefined: the port and the counter are absent.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encodings;
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL);
  - alu_op and alu_control codes;
  - imm_src codes.
- Sub-module alu_decoder (alu_op, funct3, op5, funct7b5 -> alu_control) is combinational. The FSM and the imm decode stay in the top module.

Test Plan:
- Reset: rst = 1 for 2 cycles, then release. Required: state FETCH; ir_write = 1 and pc_write = 1 in the first cycle after release; all write strobes 0 while rst is high.
- lw (op 0000011): states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. Required: reg_write = 1 only in cycle 5, result_src = 01 there, imm_src = 00 throughout.
- sw (op 0100011): mem_write = 1 only in cycle 4, adr_src = 1, imm_src = 01.
- beq: with zero = 1 in cycle 3, pc_write = 1 and alu_control = 001. Repeated with zero = 0, pc_write = 0; the next state is FETCH in both cases.
- R-type: funct3 000 with funct7b5 = 1 gives alu_control = 001 in EXECR. I-type with funct7b5 = 1 gives 000. jal gives pc_write = 1 in JAL and reg_write = 1 in ALUWB, imm_src = 11.
- Illegal op 1111111 in DECODE: illegal = 1 for one cycle and no write strobes. Then rst is asserted during MEMREAD of an lw: the next state is FETCH and reg_write is never asserted.
